hamming_decoder_stream: RTL and testbench
=========================================

// Module: hamming_decoder_stream
// PURPOSE
//  Streaming Hamming(7,4) single-error-correcting decoder; receive-side counterpart of Hamming_encoder.
//  Accepts 7-bit codewords over a valid/ready interface and returns corrected 4-bit data, a corrected flag and the syndrome.
//  Two-stage registered pipeline with full backpressure; sits between the channel/demod and the data sink.
//  Codeword layout (bit6..bit0) = {p1,p2,d3,p4,d2,d1,d0}:
//  - bit6 = Hamming position 1; bit0 = position 7.
//  - p1 = d3^d2^d0; p2 = d3^d1^d0; p4 = d2^d1^d0.
// PARAMETERS
//  CNT_W   16   width of corrected-error counter (used only with HAM_ERR_CNT_EN)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  in_valid      in   1      in_code valid
//  in_ready      out  1      decoder can accept in_code this cycle
//  in_code       in   7      received codeword, layout above
//  out_valid     out  1      out_* fields valid
//  out_ready     in   1      sink accepts output this cycle
//  out_data      out  4      corrected data {d3,d2,d1,d0}
//  out_corrected out  1      1 = syndrome nonzero, one bit was flipped
//  out_syndrome  out  3      {s4,s2,s1}; nonzero value = position (1..7) of the bit in error
//  err_cnt_clr   in   1      sync clear of err_cnt (HAM_ERR_CNT_EN only)
//  err_cnt       out  CNT_W  saturating count of corrected words (HAM_ERR_CNT_EN only)
// BEHAVIOUR
//  Syndrome equations:
//  - s1 = c6^c4^c2^c0; s2 = c5^c4^c1^c0; s4 = c3^c2^c1^c0.
//  - Syndrome k!=0 flips c[7-k]; data = {c4,c2,c1,c0} after correction.
//  Stage 1:
//  - on accept (in_valid & in_ready) registers the codeword and its syndrome, sets s1_valid.
//  Stage 2:
//  - registers the corrected data, flag and syndrome; drives out_* directly from flops.
//  Handshake:
//  - s2_load = s1_valid & (~out_valid | out_ready).
//  - in_ready = ~s1_valid | s2_load (combinational from out_ready).
//  - out_* hold stable while out_valid & ~out_ready.
//  - Stage 1 is not overwritten while stalled.
//  Timing:
//  - Latency: 2 cycles from accept to out_valid.
//  - Throughput: 1 word/cycle when out_ready is held high.
//  - No bubbles inserted; no word dropped or duplicated under any in_valid/out_ready pattern.
//  Simultaneous events: accept and output handshake in the same cycle are both honoured.
//  Reset (async assert, any time including mid-stream):
//  - s1_valid = out_valid = 0; out_data = 0; out_corrected = 0; out_syndrome = 0; err_cnt = 0.
//  - Words in flight are discarded.
//  - in_ready = 1 after reset.
//  Double-bit errors are undetectable in (7,4) and are miscorrected; out_corrected = 1 in that case. This is required behaviour.
// CONFIGURATION
//  HAM_ERR_CNT_EN defined:
//  - err_cnt increments by 1 on each output handshake with out_corrected = 1.
//  - err_cnt saturates at 2^CNT_W-1.
//  - err_cnt_clr forces 0 and wins over a same-cycle increment.
//  HAM_ERR_CNT_EN undefined:
//  - err_cnt is tied to 0; err_cnt_clr is ignored.
//  - No counter flops are present.
// STRUCTURE
//  hamming_pkg:
//  - constants HAM_N = 7 and HAM_K = 4.
//  - bit-index localparams for p1, p2, p4, d3..d0.
//  - syndrome type (3-bit).
//  Sub-module hamming_syndrome:
//  - purely combinational: in 7-bit code, out syndrome and corrected data.
//  - instantiated once, in stage 1.
// TESTING
//  - Reset, then in_code = 7'b1001100 with out_ready = 1 -> 2 cycles later out_data = 4'b0100, out_corrected = 0, out_syndrome = 0.
//  - in_code = 7'b1001101 -> out_data = 4'b0100, out_corrected = 1, out_syndrome = 3'd7.
//    in_code = 7'b1101010 -> out_data = 4'b0010, out_syndrome = 3'd1.
//  - All 16 data values x 8 error patterns (none, each single bit), back-to-back:
//    - out_data equals the original data every time.
//    - One output per cycle.
//  - out_ready low for 5 cycles during a 6-word burst:
//    - out_* stable while stalled.
//    - in_ready low once both stages are full.
//    - All 6 words are delivered in order, with no loss or duplication.
//  - Assert rst_n low with 2 words in flight -> out_valid = 0 immediately, in_ready = 1 after release, no stale output appears.
//  - HAM_ERR_CNT_EN, CNT_W = 2:
//    - 5 corrected words -> err_cnt saturates at 3.
//    - err_cnt_clr coincident with a corrected handshake -> err_cnt = 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) receive path.
// Codeword layout (bit6..bit0) = {p1,p2,d3,p4,d2,d1,d0}.
package hamming_pkg;

  localparam int HAM_N = 7;
  localparam int HAM_K = 4;

  localparam int P1_BIT = 6;
  localparam int P2_BIT = 5;
  localparam int D3_BIT = 4;
  localparam int P4_BIT = 3;
  localparam int D2_BIT = 2;
  localparam int D1_BIT = 1;
  localparam int D0_BIT = 0;

  typedef logic [2:0] syndrome_t;

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(7,4) syndrome calculation and single-bit correction.
// Syndrome {s4,s2,s1} = k != 0 names Hamming position k, i.e. code bit 7-k.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [HAM_N-1:0] code,
  output syndrome_t        syndrome,
  output logic [HAM_K-1:0] data
);

  logic [HAM_N-1:0] fixed;

  always_comb begin
    syndrome[0] = code[P1_BIT] ^ code[D3_BIT] ^ code[D2_BIT] ^ code[D0_BIT];
    syndrome[1] = code[P2_BIT] ^ code[D3_BIT] ^ code[D1_BIT] ^ code[D0_BIT];
    syndrome[2] = code[P4_BIT] ^ code[D2_BIT] ^ code[D1_BIT] ^ code[D0_BIT];
  end

  // Decode the syndrome into a one-hot flip so every index stays constant.
  always_comb begin
    fixed = code;
    for (int k = 1; k <= HAM_N; k++) begin
      if (syndrome == 3'(k)) begin
        fixed[HAM_N-k] = ~code[HAM_N-k];
      end
    end
    data = {fixed[D3_BIT], fixed[D2_BIT], fixed[D1_BIT], fixed[D0_BIT]};
  end

endmodule

// File: rtl/hamming_decoder_stream.sv
// Streaming Hamming(7,4) decoder: two-stage valid/ready pipeline with full backpressure.
// Optional corrected-word counter enabled by defining HAM_ERR_CNT_EN.
module hamming_decoder_stream
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [HAM_N-1:0] in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HAM_K-1:0] out_data,
  output logic             out_corrected,
  output logic [2:0]       out_syndrome,
  input  logic             err_cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  syndrome_t        calc_syndrome;
  logic [HAM_K-1:0] calc_data;

  logic             s1_valid;
  syndrome_t        s1_syndrome;
  logic [HAM_K-1:0] s1_data;
  logic             s2_load;

  hamming_syndrome u_syndrome (
    .code     (in_code),
    .syndrome (calc_syndrome),
    .data     (calc_data)
  );

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;

  // Stage 1 keeps its contents whenever in_ready is low, so a stalled word survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_syndrome <= '0;
      s1_data     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_syndrome <= calc_syndrome;
        s1_data     <= calc_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_corrected <= 1'b0;
      out_syndrome  <= '0;
    end else if (s2_load) begin
      out_valid     <= 1'b1;
      out_data      <= s1_data;
      out_corrected <= (s1_syndrome != '0);
      out_syndrome  <= s1_syndrome;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HAM_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Clear has priority over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_cnt_clr) begin
      err_cnt_q <= '0;
    end else if (out_valid && out_ready && out_corrected && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_cnt_clr;

  assign unused_err_cnt_clr = err_cnt_clr;
  assign err_cnt            = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder_stream.sv
// Directed self-checking bench for hamming_decoder_stream.
// Define HAM_ERR_CNT_EN to also exercise the saturating counter with CNT_W = 2.
module tb_hamming_decoder_stream;

`ifdef HAM_ERR_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_code = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_data;
  logic             out_corrected;
  logic [2:0]       out_syndrome;
  logic             err_cnt_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int check_cnt = 0;
  int pass_cnt  = 0;

  hamming_decoder_stream #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_corrected (out_corrected),
    .out_syndrome  (out_syndrome),
    .err_cnt_clr   (err_cnt_clr),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3]^d[2]^d[0], d[3]^d[1]^d[0], d[3], d[2]^d[1]^d[0], d[2], d[1], d[0]};
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    check_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    check_cnt++;
    if ({out_corrected, out_syndrome, out_data} !== 8'h00)
      $display("[TB] FAIL reset_out_fields: got %h want 00", {out_corrected, out_syndrome, out_data});
    else pass_cnt++;
    check_cnt++;
    if (err_cnt !== '0) $display("[TB] FAIL reset_err_cnt: got %0d want 0", err_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [6:0] codes [3] = '{7'b1001100, 7'b1001101, 7'b1101010};
    logic [7:0] expv  [3] = '{{1'b0, 3'd0, 4'b0100}, {1'b1, 3'd7, 4'b0100}, {1'b1, 3'd1, 4'b0010}};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = codes[i];
      @(negedge clk);
      in_valid = 1'b0;
      check_cnt++;
      if (out_valid !== 1'b0) $display("[TB] FAIL basic_latency_%0d: out_valid got %b want 0", i, out_valid);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if ({out_valid, out_corrected, out_syndrome, out_data} !== {1'b1, expv[i]})
        $display("[TB] FAIL basic_vec_%0d: got %h want %h", i,
                 {out_valid, out_corrected, out_syndrome, out_data}, {1'b1, expv[i]});
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    logic [7:0] e;
    logic [3:0] d;
    logic [6:0] mask;
    logic [2:0] syn;
    int p;
    int outs = 0;
    int gaps = 0;
    int stalls = 0;
    bit started = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 136; c++) begin
      @(negedge clk);
      if (out_valid) begin
        started = 1;
        outs++;
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL b2b_extra_word: got %h with nothing outstanding", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_corrected, out_syndrome, out_data} !== e)
            $display("[TB] FAIL b2b_word_%0d: got %h want %h", outs - 1,
                     {out_corrected, out_syndrome, out_data}, e);
          else pass_cnt++;
        end
      end else if (started && outs < 128) begin
        gaps++;
      end
      if (c < 128) begin
        d        = 4'(c / 8);
        p        = c % 8;
        mask     = (p == 0) ? 7'd0 : 7'(1 << (p - 1));
        syn      = (p == 0) ? 3'd0 : 3'(8 - p);
        in_valid = 1'b1;
        in_code  = encode(d) ^ mask;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) exp_q.push_back({p != 0, syn, d});
      else if (in_valid) stalls++;
    end
    check_cnt++;
    if (outs !== 128) $display("[TB] FAIL b2b_count: got %0d want 128", outs);
    else pass_cnt++;
    check_cnt++;
    if (gaps !== 0) $display("[TB] FAIL b2b_bubbles: got %0d want 0", gaps);
    else pass_cnt++;
    check_cnt++;
    if (stalls !== 0) $display("[TB] FAIL b2b_in_stalls: got %0d want 0", stalls);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [3:0] data [6] = '{4'hA, 4'h5, 4'hF, 4'h0, 4'h3, 4'hC};
    int         errp [6] = '{0, 3, 7, 1, 0, 5};
    logic [7:0] exp_q [$];
    logic [7:0] e;
    logic [7:0] hold_val = '0;
    bit hold_chk = 0;
    int idx = 0;
    int outn = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (hold_chk) begin
        check_cnt++;
        if ({out_valid, out_corrected, out_syndrome, out_data} !== {1'b1, hold_val})
          $display("[TB] FAIL bp_hold_c%0d: got %h want %h", c,
                   {out_valid, out_corrected, out_syndrome, out_data}, {1'b1, hold_val});
        else pass_cnt++;
        hold_chk = 0;
      end
      out_ready = !(c >= 2 && c < 7);
      in_valid  = (idx < 6);
      if (idx < 6)
        in_code = encode(data[idx]) ^ ((errp[idx] == 0) ? 7'd0 : 7'(1 << (errp[idx] - 1)));
      #1;
      if (c == 2) begin
        check_cnt++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready_full: got %b want 0", in_ready);
        else pass_cnt++;
      end
      if (out_valid && !out_ready) begin
        hold_chk = 1;
        hold_val = {out_corrected, out_syndrome, out_data};
      end
      if (out_valid && out_ready) begin
        check_cnt++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL bp_extra_word: got %h with nothing outstanding", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_corrected, out_syndrome, out_data} !== e)
            $display("[TB] FAIL bp_word_%0d: got %h want %h", outn,
                     {out_corrected, out_syndrome, out_data}, e);
          else pass_cnt++;
        end
        outn++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({errp[idx] != 0, (errp[idx] == 0) ? 3'd0 : 3'(8 - errp[idx]), data[idx]});
        idx++;
      end
    end
    in_valid = 1'b0;
    check_cnt++;
    if (outn !== 6 || idx !== 6) $display("[TB] FAIL bp_count: got out=%0d in=%0d want 6/6", outn, idx);
    else pass_cnt++;
    check_cnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp_drained: out_valid got %b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = encode(4'(i + 9));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_cnt++;
    if (out_valid !== 1'b1) $display("[TB] FAIL rst_mid_pre: out_valid got %b want 1", out_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({out_valid, out_data} !== 5'b0) $display("[TB] FAIL rst_mid_async: got %h want 00", {out_valid, out_data});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_cnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL rst_mid_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_cnt++;
    if (stale !== 0) $display("[TB] FAIL rst_mid_stale: got %0d outputs want 0", stale);
    else pass_cnt++;
  endtask

`ifdef HAM_ERR_CNT_EN
  task automatic test_err_cnt();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    check_cnt++;
    if (err_cnt !== 2'd0) $display("[TB] FAIL cnt_clear: got %0d want 0", err_cnt);
    else pass_cnt++;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = encode(4'(n)) ^ 7'b0000001;
      if (n == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (err_cnt !== 2'd1) $display("[TB] FAIL cnt_one: got %0d want 1", err_cnt);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_cnt++;
    if (err_cnt !== 2'd3) $display("[TB] FAIL cnt_saturate: got %0d want 3", err_cnt);
    else pass_cnt++;
    in_valid = 1'b1;
    in_code  = encode(4'h6) ^ 7'b0100000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({out_valid, out_corrected} !== 2'b11) $display("[TB] FAIL cnt_clr_pre: got %b want 11", {out_valid, out_corrected});
    else pass_cnt++;
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    check_cnt++;
    if ({out_valid, err_cnt} !== {1'b0, 2'd0}) $display("[TB] FAIL cnt_clr_wins: got %b want 000", {out_valid, err_cnt});
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
`ifdef HAM_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
